// File: rtl/cfg_bus_master_pkg.sv
// -----------------------------------------------------------------------------
// cgra_cfg_pkg
// Shared types and constants for the tile configuration bus master.
//   CFG_ADDR_W / CFG_DATA_W : default config address / data widths
//   cfg_state_e             : master FSM states (VERIFY only reachable when
//                             CFG_WRITE_VERIFY_EN is defined)
//   cfg_op_e                : request operation
//   cfg_req_t               : one complete request (op, addr, data)
// -----------------------------------------------------------------------------
package cgra_cfg_pkg;

    localparam int CFG_ADDR_W = 32;
    localparam int CFG_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        READ   = 3'd2,
        RESP   = 3'd3,
        VERIFY = 3'd4
    } cfg_state_e;

    typedef enum logic {
        CFG_RD = 1'b0,
        CFG_WR = 1'b1
    } cfg_op_e;

    typedef struct packed {
        cfg_op_e               op;
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] data;
    } cfg_req_t;

endpackage

// File: rtl/cfg_bus_master_if.sv
// -----------------------------------------------------------------------------
// cfg_bus_master_if
// Bundles the three channels handled by cfg_bus_master:
//   request  : req_valid, req_ready, req_write, req_addr, req_data
//   response : rsp_valid, rsp_ready, rsp_data
//   config   : config_addr, config_data, config_en, read_data
// modport master : the view of cfg_bus_master itself
// modport slave  : the view of the surroundings (controller + tile target)
// -----------------------------------------------------------------------------
interface cfg_bus_master_if
    import cgra_cfg_pkg::*;
#(
    parameter int ADDR_W = CFG_ADDR_W,
    parameter int DATA_W = CFG_DATA_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    logic [ADDR_W-1:0] config_addr;
    logic [DATA_W-1:0] config_data;
    logic              config_en;
    logic [DATA_W-1:0] read_data;

    modport master (
        input  req_valid, req_write, req_addr, req_data,
        input  rsp_ready,
        input  read_data,
        output req_ready,
        output rsp_valid, rsp_data,
        output config_addr, config_data, config_en
    );

    modport slave (
        output req_valid, req_write, req_addr, req_data,
        output rsp_ready,
        output read_data,
        input  req_ready,
        input  rsp_valid, rsp_data,
        input  config_addr, config_data, config_en
    );

endinterface

// File: rtl/cfg_bus_master_rsp_slot.sv
// -----------------------------------------------------------------------------
// cfg_rsp_slot
// One-entry valid/ready holding register for read responses. Data is held
// stable while valid is high and the consumer is not ready.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : capture load_data and raise valid (only issued when empty)
//   load_data  : data to capture
//   ready      : consumer accepts the held entry
//   valid      : entry present
//   data       : held entry
// -----------------------------------------------------------------------------
module cfg_rsp_slot
    import cgra_cfg_pkg::*;
#(
    parameter int DATA_W = CFG_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            // data is left as-is; only valid drops on the handshake
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cfg_bus_master.sv
// -----------------------------------------------------------------------------
// cfg_bus_master
// Initiator for one tile's configuration port. Each accepted request becomes
// a single config-bus operation; only one operation is ever outstanding.
// Writes drive config_en for exactly one cycle; reads hold the address for
// READ_LATENCY cycles, capture read_data and return it on the response channel.
//
// Optional build macro: CFG_WRITE_VERIFY_EN
//   When defined, every write is followed by READ_LATENCY cycles of readback
//   of the same address; a mismatch sets the sticky verify_err output and
//   loads verify_addr with the failing address.
//
// Ports:
//   clk         : clock
//   reset       : synchronous active-high reset
//   bus         : cfg_bus_master_if.master (request, response, config bus)
//   busy        : high whenever the FSM is not in IDLE
//   verify_err  : (CFG_WRITE_VERIFY_EN only) sticky write-verify failure
//   verify_addr : (CFG_WRITE_VERIFY_EN only) address of the last failure
//
// All outputs come straight from flops.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | req_ready=1, waiting for a request
// WRITE  | config_en=1 for this single cycle; target commits at its end
// READ   | address held, config_en=0, counting READ_LATENCY cycles
// RESP   | rsp_valid=1, waiting for rsp_ready
// VERIFY | after a write: readback for READ_LATENCY cycles, then compare
// -----------------------------------------------------------------------------
module cfg_bus_master
    import cgra_cfg_pkg::*;
#(
    parameter int ADDR_W       = CFG_ADDR_W,
    parameter int DATA_W       = CFG_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    cfg_bus_master_if.master  bus,
    output logic              busy
`ifdef CFG_WRITE_VERIFY_EN
    ,
    output logic              verify_err,
    output logic [ADDR_W-1:0] verify_addr
`endif
);

    generate
        if (READ_LATENCY < 1) begin : g_bad_read_latency
            $error("cfg_bus_master: READ_LATENCY must be at least 1");
        end
    endgenerate

    // Counter runs 0 .. READ_LATENCY-1 and restarts at 0 for every operation.
    localparam int              CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LATENCY - 1);

    cfg_state_e        state_q, state_d;
    logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] config_addr_q, config_addr_d;
    logic [DATA_W-1:0] config_data_q, config_data_d;
    logic              config_en_q, config_en_d;
    logic              req_ready_q;
    logic              busy_q;

    logic              rsp_load;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic              req_fire;
    logic              rsp_fire;
    logic              lat_done;
    cfg_op_e           req_op;

`ifdef CFG_WRITE_VERIFY_EN
    logic              verify_err_q, verify_err_d;
    logic [ADDR_W-1:0] verify_addr_q, verify_addr_d;
`endif

    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        config_addr_d = config_addr_q;
        config_data_d = config_data_q;
        config_en_d   = 1'b0;
        rsp_load      = 1'b0;
        req_fire      = bus.req_valid && req_ready_q;
        rsp_fire      = rsp_valid_q && bus.rsp_ready;
        lat_done      = (lat_cnt_q == LAT_LAST);
        req_op        = bus.req_write ? CFG_WR : CFG_RD;
`ifdef CFG_WRITE_VERIFY_EN
        verify_err_d  = verify_err_q;
        verify_addr_d = verify_addr_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    config_addr_d = bus.req_addr;
                    lat_cnt_d     = '0;
                    if (req_op == CFG_WR) begin
                        state_d       = WRITE;
                        config_data_d = bus.req_data;
                        config_en_d   = 1'b1;
                    end else begin
                        state_d       = READ;
                        config_data_d = '0;
                    end
                end
            end

            WRITE: begin
`ifdef CFG_WRITE_VERIFY_EN
                state_d = VERIFY;
`else
                state_d = IDLE;
`endif
            end

            READ: begin
                if (lat_done) begin
                    state_d  = RESP;
                    rsp_load = 1'b1;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end

            RESP: begin
                if (rsp_fire) begin
                    state_d = IDLE;
                end
            end

            VERIFY: begin
`ifdef CFG_WRITE_VERIFY_EN
                // config_data still holds the written value, so it doubles
                // as the compare reference.
                if (lat_done) begin
                    state_d = IDLE;
                    if (bus.read_data != config_data_q) begin
                        verify_err_d  = 1'b1;
                        verify_addr_d = config_addr_q;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            lat_cnt_q     <= '0;
            config_addr_q <= '0;
            config_data_q <= '0;
            config_en_q   <= 1'b0;
            req_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            config_addr_q <= config_addr_d;
            config_data_q <= config_data_d;
            config_en_q   <= config_en_d;
            // Registered from the next state so both line up with state_q.
            req_ready_q   <= (state_d == IDLE);
            busy_q        <= (state_d != IDLE);
        end
    end

`ifdef CFG_WRITE_VERIFY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            verify_err_q  <= 1'b0;
            verify_addr_q <= '0;
        end else begin
            verify_err_q  <= verify_err_d;
            verify_addr_q <= verify_addr_d;
        end
    end

    assign verify_err  = verify_err_q;
    assign verify_addr = verify_addr_q;
`endif

    cfg_rsp_slot #(
        .DATA_W (DATA_W)
    ) u_rsp_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (rsp_load),
        .load_data (bus.read_data),
        .ready     (bus.rsp_ready),
        .valid     (rsp_valid_q),
        .data      (rsp_data_q)
    );

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.config_addr = config_addr_q;
    assign bus.config_data = config_data_q;
    assign bus.config_en   = config_en_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_cfg_bus_master.sv
// -----------------------------------------------------------------------------
// tb_cfg_bus_master
// Two masters share one clock: u_dut1 (READ_LATENCY=1) carries the table,
// random and hand-written sequences; u_dut3 (READ_LATENCY=3) covers the longer
// latency and reset in the middle of a read. Each drives a small register-file
// target (16 words, indexed by config_addr[3:0]).
// -----------------------------------------------------------------------------
module tb_cfg_bus_master;
    import cgra_cfg_pkg::*;

    localparam int L1 = 1;
    localparam int L3 = 3;
`ifdef CFG_WRITE_VERIFY_EN
    localparam int WSP1 = 2 + L1;
`else
    localparam int WSP1 = 2;
`endif

    logic clk = 1'b0;
    logic rst1, rst3;
    logic busy1, busy3;
    logic stuck0 = 1'b0;

    always #5 clk = ~clk;

    cfg_bus_master_if b1 ();
    cfg_bus_master_if b3 ();

`ifdef CFG_WRITE_VERIFY_EN
    logic        verify_err1, verify_err3;
    logic [31:0] verify_addr1, verify_addr3;
`endif

    cfg_bus_master #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(L1)) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (b1),
        .busy  (busy1)
`ifdef CFG_WRITE_VERIFY_EN
        , .verify_err (verify_err1), .verify_addr (verify_addr1)
`endif
    );

    cfg_bus_master #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(L3)) u_dut3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (b3),
        .busy  (busy3)
`ifdef CFG_WRITE_VERIFY_EN
        , .verify_err (verify_err3), .verify_addr (verify_addr3)
`endif
    );

    // Targets: commit on the edge ending a config_en cycle, reset wins.
    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];

    assign b1.read_data = stuck0 ? 32'h0 : mem1[b1.config_addr[3:0]];
    assign b3.read_data = mem3[b3.config_addr[3:0]];

    always @(posedge clk) begin
        if (b1.config_en && !rst1) mem1[b1.config_addr[3:0]] <= b1.config_data;
        if (b3.config_en && !rst3) mem3[b3.config_addr[3:0]] <= b3.config_data;
    end

    // config_en must never stay high two cycles running.
    int   en_dbl = 0;
    logic en_prev1 = 1'b0;
    int   leak3 = 0;
    logic watch3 = 1'b0;
    always @(posedge clk) begin
        if (b1.config_en && en_prev1) en_dbl++;
        en_prev1 <= b1.config_en;
        if (watch3 && b3.rsp_valid) leak3++;
    end

    // Reference model: expected contents of the dut1 target.
    logic [31:0] ref_mem [16];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy1();
        int n = 0;
        while (!b1.req_ready && n < 50) begin step(); n++; end
        check("rdy1_timeout", (n < 50), 1);
    endtask

    task automatic wait_rdy3();
        int n = 0;
        while (!b3.req_ready && n < 50) begin step(); n++; end
        check("rdy3_timeout", (n < 50), 1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        wait_rdy1();
        b1.req_valid = 1'b1;
        b1.req_write = 1'b1;
        b1.req_addr  = a;
        b1.req_data  = d;
        step();
        b1.req_valid = 1'b0;
        b1.req_data  = $urandom;
        check("wr_en_high", b1.config_en, 1);
        check("wr_addr", b1.config_addr, a);
        check("wr_data", b1.config_data, d);
        check("wr_busy", busy1, 1);
        check("wr_not_ready", b1.req_ready, 0);
        step();
`ifdef CFG_WRITE_VERIFY_EN
        for (int i = 0; i < L1; i++) begin
            check("vf_en_low", b1.config_en, 0);
            check("vf_busy", busy1, 1);
            step();
        end
`endif
        check("wr_en_low", b1.config_en, 0);
        check("wr_idle_busy", busy1, 0);
        check("wr_idle_ready", b1.req_ready, 1);
        ref_mem[a[3:0]] = d;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input int hold);
        int   n = 0;
        logic en_seen = 1'b0;
        wait_rdy1();
        b1.req_valid = 1'b1;
        b1.req_write = 1'b0;
        b1.req_addr  = a;
        b1.req_data  = $urandom;
        b1.rsp_ready = 1'b0;
        step();
        b1.req_valid = 1'b0;
        check("rd_addr", b1.config_addr, a);
        check("rd_cdata_zero", b1.config_data, 0);
        check("rd_not_ready", b1.req_ready, 0);
        while (!b1.rsp_valid && n < 20) begin
            en_seen |= b1.config_en;
            step();
            n++;
        end
        check("rd_latency", n, L1);
        check("rd_rsp_data", b1.rsp_data, exp);
        for (int i = 0; i < hold; i++) begin
            en_seen |= b1.config_en;
            step();
            check("hold_valid", b1.rsp_valid, 1);
            check("hold_data", b1.rsp_data, exp);
            check("hold_not_ready", b1.req_ready, 0);
            check("hold_addr", b1.config_addr, a);
        end
        en_seen |= b1.config_en;
        check("rd_en_never", en_seen, 0);
        b1.rsp_ready = 1'b1;
        step();
        b1.rsp_ready = 1'b0;
        check("rsp_drop", b1.rsp_valid, 0);
        check("rsp_ready_back", b1.req_ready, 1);
        check("rsp_busy_low", busy1, 0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        int          hold;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] ra, rd;
    logic [7:0]  pat;
    int          n3;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0,          0};
        vecs[1]  = '{1'b0, 32'h0000_0000, 32'h0,          32'h0000_0001, 0};
        vecs[2]  = '{1'b1, 32'h0000_0003, 32'h0000_007A, 32'h0,          0};
        vecs[3]  = '{1'b0, 32'h0000_0003, 32'h0,          32'h0000_007A, 0};
        vecs[4]  = '{1'b1, 32'hABCD_0005, 32'hDEAD_BEEF, 32'h0,          0};
        vecs[5]  = '{1'b0, 32'hABCD_0005, 32'h0,          32'hDEAD_BEEF, 3};
        vecs[6]  = '{1'b0, 32'h0000_0006, 32'h0,          32'h0,          1};
        vecs[7]  = '{1'b1, 32'h0000_000F, 32'hFFFF_FFFF, 32'h0,          0};
        vecs[8]  = '{1'b0, 32'h0000_000F, 32'h0,          32'hFFFF_FFFF, 0};
        vecs[9]  = '{1'b1, 32'h0000_0003, 32'h0000_0000, 32'h0,          0};
        vecs[10] = '{1'b0, 32'h0000_0003, 32'h0,          32'h0,          2};

        for (int i = 0; i < 16; i++) begin
            mem1[i]    = 32'h0;
            mem3[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0; b1.req_data = '0; b1.rsp_ready = 1'b0;
        b3.req_valid = 1'b0; b3.req_write = 1'b0; b3.req_addr = '0; b3.req_data = '0; b3.rsp_ready = 1'b0;

        // Reset
        rst1 = 1'b1;
        rst3 = 1'b1;
        repeat (3) step();
        check("rst_en", b1.config_en, 0);
        check("rst_addr", b1.config_addr, 0);
        check("rst_cdata", b1.config_data, 0);
        check("rst_rsp_valid", b1.rsp_valid, 0);
        check("rst_rsp_data", b1.rsp_data, 0);
        check("rst_busy", busy1, 0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        step();
        check("post_rst_ready1", b1.req_ready, 1);
        check("post_rst_ready3", b3.req_ready, 1);
        check("post_rst_busy", busy1, 0);

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].addr, vecs[i].exp_rd, vecs[i].hold);
        end

        // Back-to-back writes with req_valid held high
        wait_rdy1();
        b1.req_valid = 1'b1;
        b1.req_write = 1'b1;
        b1.req_addr  = 32'h9;
        b1.req_data  = 32'h8;
        step();
        pat = '0;
        for (int c = 0; c < 8; c++) begin
            pat[c] = b1.config_en;
            if (c == 0) begin
                check("b2b_first_data", b1.config_data, 32'h8);
                b1.req_data = 32'h70;
            end
            if (c == WSP1) begin
                check("b2b_second_data", b1.config_data, 32'h70);
                check("b2b_second_addr", b1.config_addr, 32'h9);
                b1.req_valid = 1'b0;
            end
            step();
        end
        check("b2b_pattern", pat, (8'h1 | (8'h1 << WSP1)));
        check("b2b_target", mem1[9], 32'h70);
        ref_mem[9] = 32'h70;
        do_read(32'h9, 32'h70, 0);

        // Randomised traffic against the reference memory
        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rd = $urandom;
            if ($urandom_range(0, 1) == 1) do_write(ra, rd);
            else                           do_read(ra, ref_mem[ra[3:0]], int'($urandom_range(0, 3)));
        end
        check("en_never_double", en_dbl, 0);

        // READ_LATENCY=3: write, read, then reset mid-read
        wait_rdy3();
        b3.req_valid = 1'b1; b3.req_write = 1'b1; b3.req_addr = 32'h1; b3.req_data = 32'h33;
        step();
        b3.req_valid = 1'b0;
        check("l3_wr_en", b3.config_en, 1);
        wait_rdy3();
        b3.req_valid = 1'b1; b3.req_write = 1'b0; b3.req_addr = 32'h1;
        step();
        b3.req_valid = 1'b0;
        n3 = 0;
        while (!b3.rsp_valid && n3 < 20) begin step(); n3++; end
        check("l3_latency", n3, L3);
        check("l3_rdata", b3.rsp_data, 32'h33);
        b3.rsp_ready = 1'b1;
        step();
        b3.rsp_ready = 1'b0;
        wait_rdy3();
        b3.req_valid = 1'b1; b3.req_write = 1'b0; b3.req_addr = 32'h1;
        step();
        b3.req_valid = 1'b0;
        watch3 = 1'b1;
        step();
        rst3 = 1'b1;
        step();
        check("l3_rst_en", b3.config_en, 0);
        check("l3_rst_addr", b3.config_addr, 0);
        check("l3_rst_cdata", b3.config_data, 0);
        check("l3_rst_valid", b3.rsp_valid, 0);
        check("l3_rst_rdata", b3.rsp_data, 0);
        check("l3_rst_busy", busy3, 0);
        step();
        rst3 = 1'b0;
        step();
        check("l3_rel_ready", b3.req_ready, 1);
        repeat (5) step();
        watch3 = 1'b0;
        check("l3_no_rsp", leak3, 0);

`ifdef CFG_WRITE_VERIFY_EN
        check("vf_err_clean", verify_err1, 0);
        stuck0 = 1'b1;
        do_write(32'h2, 32'h5);
        check("vf_err_set", verify_err1, 1);
        check("vf_addr", verify_addr1, 32'h2);
        stuck0 = 1'b0;
        do_write(32'h4, 32'h99);
        check("vf_err_sticky", verify_err1, 1);
        check("vf_addr_hold", verify_addr1, 32'h2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
